// File: rtl/tz_pkg.sv
// Shared types for the trailing-zero token encoder/decoder pair.
package tz_pkg;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int TZ_DATA_WIDTH = 8;
  localparam int TZ_CNT_W      = cnt_w(TZ_DATA_WIDTH);

  typedef enum logic [0:0] {
    ACCUM = 1'b0
  } tz_state_e;

  typedef struct packed {
    logic [TZ_CNT_W-1:0] count;
    logic                last;
  } tz_tok_t;

endpackage

// File: rtl/tz_pos_decode.sv
// Bit position -> one-hot mask; flags the legal end marker (pos == DATA_WIDTH) and overruns beyond it.
// Purely combinational, no latency, no flow control.
module tz_pos_decode
  import tz_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = cnt_w(DATA_WIDTH)
) (
  input  logic [CNT_W:0]      pos,
  output logic [DATA_WIDTH-1:0] mask,
  output logic                overrun,
  output logic                at_end
);

  localparam logic [CNT_W:0] POS_END = (CNT_W+1)'(DATA_WIDTH);

  always_comb begin
    mask    = '0;
    overrun = (pos > POS_END);
    at_end  = (pos == POS_END);
    for (int i = 0; i < DATA_WIDTH; i++) begin
      mask[i] = (pos == (CNT_W+1)'(i));
    end
  end

endmodule

// File: rtl/tz_word_builder.sv
// Rebuilds a word from zero-run tokens (skip k zeros, then a 1); word is valid one cycle after its last token.
// One-entry output register: tokens stall only while a word is held and out_ready is low.
module tz_word_builder
  import tz_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = cnt_w(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tok_valid,
  output logic                  tok_ready,
  input  logic [CNT_W-1:0]      tok_count,
  input  logic                  tok_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err
);

  localparam logic [CNT_W-1:0] PTR_END = CNT_W'(DATA_WIDTH);

  tz_state_e             state;
  logic [CNT_W-1:0]      ptr;
  logic [DATA_WIDTH-1:0] accum;
  logic                  err_acc;

  logic [CNT_W:0]        pos;
  logic [DATA_WIDTH-1:0] mask;
  logic                  overrun;
  logic                  at_end;
  logic                  accept;

  // One extra bit so ptr + count can never wrap back into the word.
  assign pos       = {1'b0, ptr} + {1'b0, tok_count};
  assign tok_ready = !out_valid || out_ready;
  assign accept    = tok_valid && tok_ready;

  tz_pos_decode #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_pos_decode (
    .pos     (pos),
    .mask    (mask),
    .overrun (overrun),
    .at_end  (at_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      ptr       <= '0;
      accum     <= '0;
      err_acc   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
          // A last token overrides the retire above, so back-to-back words keep out_valid high.
          if (accept) begin
            if (tok_last) begin
              out_data  <= accum | mask;
              out_err   <= err_acc | overrun;
              out_valid <= 1'b1;
              accum     <= '0;
              ptr       <= '0;
              err_acc   <= 1'b0;
            end else begin
              accum   <= accum | mask;
              err_acc <= err_acc | overrun;
              ptr     <= (overrun || at_end) ? PTR_END : pos[CNT_W-1:0] + CNT_W'(1);
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_tz_word_builder.sv
// Table-driven token stream with a scoreboard of expected words, plus stall and reset sequences.
module tb_tz_word_builder;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          tok_valid;
  logic          tok_ready;
  logic [CW-1:0] tok_count;
  logic          tok_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_err;

  tz_word_builder #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tok_valid (tok_valid),
    .tok_ready (tok_ready),
    .tok_count (tok_count),
    .tok_last  (tok_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] count;
    logic          last;
    logic [DW-1:0] exp_data;
    logic          exp_err;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Holds a token until accepted; expected word goes to the scoreboard on acceptance of a last token.
  task automatic send_tok(input logic [CW-1:0] c, input logic l, input logic [DW-1:0] ed,
                          input logic ee, output int stalls);
    bit done;
    exp_t e;
    done      = 1'b0;
    stalls    = 0;
    tok_valid = 1'b1;
    tok_count = c;
    tok_last  = l;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (tok_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
        if (l) begin
          e.data = ed;
          e.err  = ee;
          e.cyc  = cyc;
          q.push_back(e);
        end
      end else begin
        stalls++;
      end
    end
    tok_valid = 1'b0;
    if (!done) check("tok_accept_timeout", 0, 1);
  endtask

  // Monitor: a newly loaded word must appear right after its last token's edge; retired words are scored.
  bit prev_valid = 1'b0;
  bit prev_hs    = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (out_valid && (!prev_valid || prev_hs)) begin
        if (q.size() == 0) check("unexpected_word", 1, 0);
        else check("word_latency_cyc", cyc, q[0].cyc);
      end
      if (out_valid && out_ready && q.size() != 0) begin
        e = q.pop_front();
        check("out_data", out_data, e.data);
        check("out_err", out_err, e.err);
      end
      prev_valid = out_valid;
      prev_hs    = out_valid && out_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input int c, input bit l, input int d, input bit e);
    vec_t v;
    v.count    = CW'(c);
    v.last     = l;
    v.exp_data = DW'(d);
    v.exp_err  = e;
    return v;
  endfunction

  vec_t vecs[24];
  int   st;

  initial begin
    vecs[0]  = mk(8, 1, 8'h00, 0);
    vecs[1]  = mk(0, 0, 0, 0);
    vecs[2]  = mk(3, 1, 8'h11, 0);
    vecs[3]  = mk(2, 0, 0, 0);
    vecs[4]  = mk(2, 0, 0, 0);
    vecs[5]  = mk(1, 1, 8'hA4, 0);
    vecs[6]  = mk(0, 1, 8'h01, 0);
    vecs[7]  = mk(4, 1, 8'h10, 0);
    vecs[8]  = mk(7, 1, 8'h80, 0);
    vecs[9]  = mk(6, 0, 0, 0);
    vecs[10] = mk(5, 1, 8'h40, 1);
    vecs[11] = mk(1, 1, 8'h02, 0);
    vecs[12] = mk(8, 0, 0, 0);
    vecs[13] = mk(0, 1, 8'h00, 0);
    vecs[14] = mk(7, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 0);
    vecs[16] = mk(0, 1, 8'h80, 0);
    vecs[17] = mk(8, 0, 0, 0);
    vecs[18] = mk(1, 1, 8'h00, 1);
    vecs[19] = mk(15, 1, 8'h00, 1);
    vecs[20] = mk(1, 0, 0, 0);
    vecs[21] = mk(1, 0, 0, 0);
    vecs[22] = mk(1, 0, 0, 0);
    vecs[23] = mk(1, 1, 8'hAA, 0);

    rst_n     = 1'b0;
    tok_valid = 1'b0;
    tok_count = '0;
    tok_last  = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);
    check("rst_tok_ready", tok_ready, 1);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Continuous stream with out_ready high: no token may ever stall.
    for (int i = 0; i < 24; i++) begin
      send_tok(vecs[i].count, vecs[i].last, vecs[i].exp_data, vecs[i].exp_err, st);
      check($sformatf("vec%0d_stalls", i), st, 0);
    end

    // Backpressure: held word stays stable, next token waits, then both retire in order.
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    send_tok(4'd4, 1'b1, 8'h10, 1'b0, st);
    fork
      begin
        int st2;
        send_tok(4'd0, 1'b1, 8'h01, 1'b0, st2);
        check("stall_cycles", st2, 3);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_tok_ready", tok_ready, 0);
          check("stall_out_valid", out_valid, 1);
          check("stall_out_data", out_data, 8'h10);
          check("stall_out_err", out_err, 0);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-word discards the partial accumulation.
    send_tok(4'd1, 1'b0, 8'h00, 1'b0, st);
    send_tok(4'd1, 1'b0, 8'h00, 1'b0, st);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_tok_ready", tok_ready, 1);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_tok(4'd0, 1'b1, 8'h01, 1'b0, st);
    repeat (2) @(posedge clk);
    #1;

    // Reset while a word is pending drops it.
    out_ready = 1'b0;
    send_tok(4'd2, 1'b1, 8'h04, 1'b0, st);
    @(negedge clk);
    check("pend_out_valid", out_valid, 1);
    check("pend_out_data", out_data, 8'h04);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("pendrst_out_valid", out_valid, 0);
    check("pendrst_out_data", out_data, 0);
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send_tok(4'd6, 1'b1, 8'h40, 1'b0, st);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drain", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
